dphy_multilane_tx: RTL

DPHY_MULTILANE_TX -- requirements
Module: dphy_multilane_tx

---
 rtl/dphy_multilane_tx.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dphy_multilane_tx.sv
// Multi-lane D-PHY style transmitter: LP-11 -> LP-01 -> LP-00 -> HS-0 -> sync byte -> payload -> trail -> LP-11.
// Every lane shifts its byte out LSB-first, one bit per TX_DDR_clk rising edge, all lanes bit-aligned.
module dphy_multilane_tx #(
    parameter int NUM_LANES    = 2,
    parameter int T_LPX        = 4,
    parameter int T_HS_PREPARE = 4,
    parameter int T_HS_ZERO    = 8,
    parameter int T_HS_TRAIL   = 8,
    parameter int T_HS_EXIT    = 4
) (
    input  logic                   TX_DDR_clk,
    input  logic                   TX_rst,
    input  logic                   TX_REQ,
    input  logic                   TX_VALID,
    input  logic [8*NUM_LANES-1:0] TX_DATA,
    output logic                   TX_READY,
    output logic [NUM_LANES-1:0]   Dp,
    output logic [NUM_LANES-1:0]   Dn,
    output logic [2:0]             TX_STATE,
    output logic                   TX_UNDERFLOW,
    output logic [15:0]            TX_BEAT_CNT
);

    typedef enum logic [2:0] {
        ST_STOP      = 3'd0,
        ST_LP_RQST   = 3'd1,
        ST_LP_BRIDGE = 3'd2,
        ST_HS_ZERO   = 3'd3,
        ST_HS_SYNC   = 3'd4,
        ST_HS_DATA   = 3'd5,
        ST_HS_TRAIL  = 3'd6,
        ST_HS_EXIT   = 3'd7
    } state_t;

    localparam logic [7:0] LPX_LAST     = 8'(T_LPX - 1);
    localparam logic [7:0] PREPARE_LAST = 8'(T_HS_PREPARE - 1);
    localparam logic [7:0] ZERO_LAST    = 8'(T_HS_ZERO - 1);
    localparam logic [7:0] TRAIL_LAST   = 8'(T_HS_TRAIL - 1);
    localparam logic [7:0] EXIT_LAST    = 8'(T_HS_EXIT - 1);
    localparam logic [7:0] SYNC_BYTE    = 8'hB8;

    state_t                    state;
    logic [7:0]                dur;
    logic [2:0]                bit_cnt;
    logic [NUM_LANES-1:0][7:0] shift;
    logic                      ready_q;
    logic                      underflow_q;
    logic [15:0]               beat_cnt;
    logic                      hs_shift;
    logic                      boundary;
    logic [NUM_LANES-1:0]      line_bits;

    // Handshake: a beat transfers on a rising edge where TX_READY and TX_VALID are both 1.
    // TX_READY is registered, so it reflects TX_REQ sampled on the edge that enters the boundary cycle.
    assign hs_shift = (state == ST_HS_SYNC) || (state == ST_HS_DATA);
    assign boundary = hs_shift && (bit_cnt == 3'd7);

    always_ff @(posedge TX_DDR_clk or posedge TX_rst) begin
        if (TX_rst) begin
            state       <= ST_STOP;
            dur         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            ready_q     <= 1'b0;
            underflow_q <= 1'b0;
            beat_cnt    <= '0;
        end else begin
            underflow_q <= 1'b0;
            ready_q     <= hs_shift && (bit_cnt == 3'd6) && TX_REQ;
            case (state)
                ST_STOP: begin
                    if (TX_REQ) begin
                        state    <= ST_LP_RQST;
                        dur      <= '0;
                        beat_cnt <= '0;
                    end
                end
                ST_LP_RQST: begin
                    if (dur == LPX_LAST) begin
                        state <= ST_LP_BRIDGE;
                        dur   <= '0;
                    end else begin
                        dur <= dur + 8'd1;
                    end
                end
                ST_LP_BRIDGE: begin
                    if (dur == PREPARE_LAST) begin
                        state <= ST_HS_ZERO;
                        dur   <= '0;
                    end else begin
                        dur <= dur + 8'd1;
                    end
                end
                ST_HS_ZERO: begin
                    if (dur == ZERO_LAST) begin
                        state   <= ST_HS_SYNC;
                        dur     <= '0;
                        bit_cnt <= '0;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            shift[i] <= SYNC_BYTE;
                        end
                    end else begin
                        dur <= dur + 8'd1;
                    end
                end
                ST_HS_SYNC, ST_HS_DATA: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (ready_q && TX_VALID) begin
                            state <= ST_HS_DATA;
                            shift <= TX_DATA;
                            if (beat_cnt != 16'hFFFF) begin
                                beat_cnt <= beat_cnt + 16'd1;
                            end
                        end else begin
                            // Trail holds the inverse of each lane's final bit; bit 0 is what the lines show.
                            state       <= ST_HS_TRAIL;
                            dur         <= '0;
                            underflow_q <= ready_q;
                            for (int i = 0; i < NUM_LANES; i++) begin
                                shift[i][0] <= ~shift[i][0];
                            end
                        end
                    end else begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            shift[i] <= {1'b0, shift[i][7:1]};
                        end
                    end
                end
                ST_HS_TRAIL: begin
                    if (dur == TRAIL_LAST) begin
                        state <= ST_HS_EXIT;
                        dur   <= '0;
                    end else begin
                        dur <= dur + 8'd1;
                    end
                end
                ST_HS_EXIT: begin
                    if (dur == EXIT_LAST) begin
                        state <= ST_STOP;
                        dur   <= '0;
                    end else begin
                        dur <= dur + 8'd1;
                    end
                end
                default: state <= ST_STOP;
            endcase
        end
    end

    always_comb begin
        line_bits = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            line_bits[i] = shift[i][0];
        end
    end

    // Line levels decode from registered state only, so no input reaches Dp/Dn combinationally.
    always_comb begin
        Dp = '1;
        Dn = '1;
        case (state)
            ST_LP_RQST: begin
                Dp = '0;
                Dn = '1;
            end
            ST_LP_BRIDGE: begin
                Dp = '0;
                Dn = '0;
            end
            ST_HS_ZERO: begin
                Dp = '0;
                Dn = '1;
            end
            ST_HS_SYNC, ST_HS_DATA, ST_HS_TRAIL: begin
                Dp = line_bits;
                Dn = ~line_bits;
            end
            default: begin
                Dp = '1;
                Dn = '1;
            end
        endcase
    end

    assign TX_STATE     = state;
    assign TX_READY     = ready_q;
    assign TX_UNDERFLOW = underflow_q;
    assign TX_BEAT_CNT  = beat_cnt;

endmodule
